stripe_issuer: RTL and testbench

Issues tagged operand blocks to a chain of compute stripes and acts as the producer end of the stripes' tag-matching input bus. For one configured job it walks two tag sequences, each with its own stride, and reads the operand block for each tag from a synchronous operand memory. It then presents matched (tag A, block A, tag B, block B) beats downstream. A small internal FIFO absorbs memory latency and downstream backpressure.

---
 rtl/stripe_issuer_pkg.sv | 22 ++
 rtl/stripe_issuer_beat_fifo.sv | 52 +++++
 rtl/stripe_issuer.sv | 129 ++++++++++++
 tb/tb_stripe_issuer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/stripe_issuer_pkg.sv
// rtl/stripe_issuer_pkg.sv - shared types and default sizes for the stripe issuer
package stripe_issuer_pkg;

  localparam int BLOCK_WIDTH_D = 128;
  localparam int TAG_WIDTH_D   = 12;
  localparam int FIFO_DEPTH_D  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FINISH
  } state_e;

  typedef struct packed {
    logic [TAG_WIDTH_D-1:0]   tag_a;
    logic [TAG_WIDTH_D-1:0]   tag_b;
    logic [BLOCK_WIDTH_D-1:0] d0;
    logic [BLOCK_WIDTH_D-1:0] d1;
  } beat_t;

endpackage

// File: rtl/stripe_issuer_beat_fifo.sv
// rtl/stripe_issuer_beat_fifo.sv - small synchronous beat FIFO with occupancy count
module beat_fifo
  import stripe_issuer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_D
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  beat_t                    push_data,
  input  logic                     pop,
  output beat_t                    head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  beat_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CW-1:0]    count_q;

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // The producer throttles requests, so a push into a full FIFO is a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CW'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (count_q == '0)));

endmodule

// File: rtl/stripe_issuer.sv
// rtl/stripe_issuer.sv - walks two strided tag sequences, reads operand blocks, emits matched beats
module stripe_issuer
  import stripe_issuer_pkg::*;
#(
  parameter int BLOCK_WIDTH = BLOCK_WIDTH_D,
  parameter int TAG_WIDTH   = TAG_WIDTH_D,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [TAG_WIDTH-1:0]   cfg_tag_a,
  input  logic [TAG_WIDTH-1:0]   cfg_tag_b,
  input  logic [TAG_WIDTH-1:0]   cfg_stride_a,
  input  logic [TAG_WIDTH-1:0]   cfg_stride_b,
  input  logic [TAG_WIDTH-1:0]   cfg_count,
  output logic                   mem_req,
  output logic [TAG_WIDTH-1:0]   mem_addr_a,
  output logic [TAG_WIDTH-1:0]   mem_addr_b,
  input  logic [BLOCK_WIDTH-1:0] mem_rdata_a,
  input  logic [BLOCK_WIDTH-1:0] mem_rdata_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TAG_WIDTH-1:0]   tagA_OUT,
  output logic [TAG_WIDTH-1:0]   tagB_OUT,
  output logic [BLOCK_WIDTH-1:0] d0_OUT,
  output logic [BLOCK_WIDTH-1:0] d1_OUT,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e               state_q;
  logic [TAG_WIDTH-1:0] tag_a_q, tag_b_q;
  logic [TAG_WIDTH-1:0] stride_a_q, stride_b_q;
  logic [TAG_WIDTH-1:0] remaining_q;
  logic [TAG_WIDTH-1:0] pipe_a_q, pipe_b_q;
  logic                 inflight_q;

  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic          fifo_empty;
  logic          room;
  logic          pop;
  beat_t         push_data;
  beat_t         head;

  // A request reserves a FIFO slot one cycle before its data lands.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q);
  assign room      = occupancy < (CW+1)'(FIFO_DEPTH);
  assign mem_req   = (state_q == ST_RUN) && (remaining_q != '0) && room;

  assign mem_addr_a = tag_a_q;
  assign mem_addr_b = tag_b_q;

  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign tagA_OUT  = head.tag_a;
  assign tagB_OUT  = head.tag_b;
  assign d0_OUT    = head.d0;
  assign d1_OUT    = head.d1;

  assign push_data = '{tag_a: pipe_a_q, tag_b: pipe_b_q, d0: mem_rdata_a, d1: mem_rdata_b};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tag_a_q     <= '0;
      tag_b_q     <= '0;
      stride_a_q  <= '0;
      stride_b_q  <= '0;
      remaining_q <= '0;
      pipe_a_q    <= '0;
      pipe_b_q    <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= mem_req;
      if (mem_req) begin
        pipe_a_q <= tag_a_q;
        pipe_b_q <= tag_b_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid) begin
            tag_a_q     <= cfg_tag_a;
            tag_b_q     <= cfg_tag_b;
            stride_a_q  <= cfg_stride_a;
            stride_b_q  <= cfg_stride_b;
            remaining_q <= cfg_count;
            state_q     <= (cfg_count == '0) ? ST_FINISH : ST_RUN;
          end
        end
        ST_RUN: begin
          if (mem_req) begin
            tag_a_q     <= tag_a_q + stride_a_q;
            tag_b_q     <= tag_b_q + stride_b_q;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == TAG_WIDTH'(1)) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((fifo_count == '0) && !inflight_q && !pop) state_q <= ST_FINISH;
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  beat_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (inflight_q),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_stripe_issuer.sv
// tb/tb_stripe_issuer.sv - directed table-driven bench for stripe_issuer
module tb_stripe_issuer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [11:0]  cfg_tag_a = '0, cfg_tag_b = '0, cfg_stride_a = '0, cfg_stride_b = '0, cfg_count = '0;
  logic         mem_req;
  logic [11:0]  mem_addr_a, mem_addr_b;
  logic [127:0] mem_rdata_a = '0, mem_rdata_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [11:0]  tagA_OUT, tagB_OUT;
  logic [127:0] d0_OUT, d1_OUT;
  logic         busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stripe_issuer dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_tag_a(cfg_tag_a), .cfg_tag_b(cfg_tag_b),
    .cfg_stride_a(cfg_stride_a), .cfg_stride_b(cfg_stride_b), .cfg_count(cfg_count),
    .mem_req(mem_req), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
    .mem_rdata_a(mem_rdata_a), .mem_rdata_b(mem_rdata_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .tagA_OUT(tagA_OUT), .tagB_OUT(tagB_OUT), .d0_OUT(d0_OUT), .d1_OUT(d1_OUT),
    .busy(busy), .done(done)
  );

  function automatic logic [127:0] blk(input logic [11:0] x);
    return {8{{4'h0, x}}};
  endfunction

  always @(posedge clk) begin
    if (mem_req) begin
      mem_rdata_a <= blk(mem_addr_a);
      mem_rdata_b <= blk(mem_addr_b);
    end
  end

  task automatic chk(input string name, input logic [279:0] act, input logic [279:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [11:0] ta, sa, tb, sb, cnt;
    bit          bp;
    bit          hold;
    logic [11:0] la, lb;
  } job_t;

  job_t tbl[7];

  task automatic drive_cfg(input job_t j);
    cfg_valid    = 1'b1;
    cfg_tag_a    = j.ta;
    cfg_tag_b    = j.tb;
    cfg_stride_a = j.sa;
    cfg_stride_b = j.sb;
    cfg_count    = j.cnt;
    out_ready    = 1'b1;
  endtask

  // Entered at the negedge of the handshake cycle (cycle 0); leaves at the negedge after done.
  task automatic run_loop(input job_t j, input job_t nxt);
    int          c = 0, idx = 0, reqs = 0, pops = 0;
    int          first_ov = -1, done_cyc = -1, last_hs = -1;
    bit          got_done = 0, stall = 0, seen_ov = 0;
    logic [11:0] ea, eb, last_a = '0, last_b = '0;
    logic [279:0] prev = '0;
    chk("cfg_ready_c0", 280'(cfg_ready), 280'(1));
    while (!got_done && c < 200) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        if (j.hold) drive_cfg(nxt);
        else cfg_valid = 1'b0;
        chk("mem_req_c1", 280'(mem_req), 280'(j.cnt != 0));
        chk("busy_c1", 280'(busy), 280'(1));
        chk("cfg_ready_c1", 280'(cfg_ready), 280'(0));
      end
      out_ready = j.bp ? c[0] : 1'b1;
      if (stall) begin
        chk("stall_valid", 280'(out_valid), 280'(1));
        chk("stall_fields", {tagA_OUT, tagB_OUT, d0_OUT, d1_OUT}, prev);
      end
      if (mem_req) chk("throttle_room", 280'((reqs - pops) < 4), 280'(1));
      if (out_valid && !seen_ov) begin
        seen_ov  = 1;
        first_ov = c;
      end
      if (out_valid && out_ready) begin
        ea = j.ta + 12'(idx) * j.sa;
        eb = j.tb + 12'(idx) * j.sb;
        chk("beat_tag_a", 280'(tagA_OUT), 280'(ea));
        chk("beat_tag_b", 280'(tagB_OUT), 280'(eb));
        chk("beat_d0", 280'(d0_OUT), 280'(blk(ea)));
        chk("beat_d1", 280'(d1_OUT), 280'(blk(eb)));
        last_a  = tagA_OUT;
        last_b  = tagB_OUT;
        last_hs = c;
        idx++;
        pops++;
      end
      stall = out_valid && !out_ready;
      prev  = {tagA_OUT, tagB_OUT, d0_OUT, d1_OUT};
      if (mem_req) reqs++;
      if (done) begin
        got_done = 1;
        done_cyc = c;
      end
    end
    chk("done_seen", 280'(got_done), 280'(1));
    if (j.cnt == 0) begin
      chk("zero_done_cycle", 280'(done_cyc), 280'(1));
      chk("zero_no_out_valid", 280'(seen_ov), 280'(0));
    end else begin
      chk("first_valid_cycle", 280'(first_ov), 280'(3));
      chk("done_after_last", 280'(done_cyc), 280'(last_hs + 2));
      chk("last_tag_a", 280'(last_a), 280'(j.la));
      chk("last_tag_b", 280'(last_b), 280'(j.lb));
    end
    chk("beat_count", 280'(idx), 280'(j.cnt));
    chk("req_count", 280'(reqs), 280'(j.cnt));
    @(negedge clk);
    chk("done_pulse", 280'(done), 280'(0));
    chk("cfg_ready_after_done", 280'(cfg_ready), 280'(1));
    out_ready = 1'b1;
  endtask

  initial begin
    job_t rj;
    //        ta      sa      tb      sb      cnt    bp hold la      lb
    tbl[0] = '{12'h000, 12'h001, 12'h100, 12'h002, 12'd4, 0, 0, 12'h003, 12'h106};
    tbl[1] = '{12'h000, 12'h001, 12'h100, 12'h002, 12'd4, 1, 0, 12'h003, 12'h106};
    tbl[2] = '{12'hFFE, 12'h001, 12'h010, 12'h003, 12'd4, 0, 0, 12'h001, 12'h019};
    tbl[3] = '{12'h000, 12'h001, 12'h000, 12'h001, 12'd0, 0, 0, 12'h000, 12'h000};
    tbl[4] = '{12'h7F0, 12'h123, 12'h800, 12'h800, 12'd6, 1, 0, 12'hD9F, 12'h000};
    tbl[5] = '{12'h020, 12'h001, 12'h020, 12'h001, 12'd3, 0, 1, 12'h022, 12'h022};
    tbl[6] = '{12'h400, 12'h004, 12'h500, 12'h000, 12'd2, 0, 0, 12'h404, 12'h500};

    @(negedge clk);
    chk("rst_cfg_ready", 280'(cfg_ready), 280'(1));
    chk("rst_mem_req", 280'(mem_req), 280'(0));
    chk("rst_out_valid", 280'(out_valid), 280'(0));
    chk("rst_busy", 280'(busy), 280'(0));
    chk("rst_done", 280'(done), 280'(0));
    chk("rst_fields", {tagA_OUT, tagB_OUT, d0_OUT, d1_OUT, mem_addr_a, mem_addr_b}, 280'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (i == 0 || !tbl[i-1].hold) drive_cfg(tbl[i]);
      run_loop(tbl[i], tbl[(i < 6) ? i + 1 : i]);
    end

    // Reset during RUN with two beats buffered and the consumer stalled.
    rj = '{12'h200, 12'h001, 12'h300, 12'h001, 12'd8, 0, 0, 12'h207, 12'h307};
    drive_cfg(rj);
    out_ready = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", 280'(out_valid), 280'(1));
    chk("pre_reset_head", 280'(tagA_OUT), 280'(12'h200));
    rst = 1'b0;
    #1;
    chk("mid_reset_valid", 280'(out_valid), 280'(0));
    chk("mid_reset_cfg_ready", 280'(cfg_ready), 280'(1));
    chk("mid_reset_mem_req", 280'(mem_req), 280'(0));
    chk("mid_reset_busy", 280'(busy), 280'(0));
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_valid", 280'(out_valid), 280'(0));
    drive_cfg(tbl[0]);
    run_loop(tbl[0], tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
